// File: rtl/pending_request_scheduler.sv
// Pending-request scheduler: latches request pulses into a pending-bit register and
// issues them one at a time, lowest index first, through a registered valid/ready port.
module pending_request_scheduler #(
    parameter  int INPUT_WIDTH = 8,
    parameter  int CNT_WIDTH   = 8,
    localparam int IDX_W       = $clog2(INPUT_WIDTH),
    localparam int PC_W        = $clog2(INPUT_WIDTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic [INPUT_WIDTH-1:0] req_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [IDX_W-1:0]       out_index,
    output logic [INPUT_WIDTH-1:0] pending,
    output logic [PC_W-1:0]        pending_count,
    output logic [CNT_WIDTH-1:0]   dup_count,
    output logic                   idle
);

    localparam int SUM_W = CNT_WIDTH + PC_W;
    localparam logic [INPUT_WIDTH-1:0] ZERO_V = {INPUT_WIDTH{1'b0}};
    localparam logic [INPUT_WIDTH-1:0] ONE_V  = {{(INPUT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [SUM_W-1:0]       SAT_V  = {{PC_W{1'b0}}, {CNT_WIDTH{1'b1}}};

    logic [INPUT_WIDTH-1:0] pending_r;
    logic                   out_valid_r;
    logic [IDX_W-1:0]       out_index_r;
    logic [CNT_WIDTH-1:0]   dup_count_r;

    logic                   load_slot_s;
    logic                   issue_s;
    logic [INPUT_WIDTH-1:0] lowest_s;
    logic [INPUT_WIDTH-1:0] issue_mask_s;
    logic [IDX_W-1:0]       sel_s;
    logic [INPUT_WIDTH-1:0] dup_vec_s;
    logic [SUM_W-1:0]       dup_sum_s;
    logic [CNT_WIDTH-1:0]   dup_next_s;

    function automatic logic [PC_W-1:0] popcount(input logic [INPUT_WIDTH-1:0] v);
        logic [PC_W-1:0] c;
        c = {PC_W{1'b0}};
        for (int i = 0; i < INPUT_WIDTH; i++) begin
            c = c + {{(PC_W-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

    // Input is guaranteed one-hot (or zero), so OR-ing the candidate indices encodes it.
    function automatic logic [IDX_W-1:0] onehot_to_index(input logic [INPUT_WIDTH-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = {IDX_W{1'b0}};
        for (int i = 0; i < INPUT_WIDTH; i++) begin
            idx = idx | (oh[i] ? IDX_W'(i) : {IDX_W{1'b0}});
        end
        return idx;
    endfunction

    // Issue selection and duplicate accounting for the current cycle.
    always_comb begin
        load_slot_s  = !out_valid_r || out_ready;
        lowest_s     = pending_r & (~pending_r + ONE_V);
        issue_s      = load_slot_s && (pending_r != ZERO_V);
        issue_mask_s = issue_s ? lowest_s : ZERO_V;
        sel_s        = onehot_to_index(lowest_s);
        // The bit being issued this cycle is excluded so a same-cycle re-request re-arms it.
        dup_vec_s    = req_in & pending_r & ~issue_mask_s;
        dup_sum_s    = {{PC_W{1'b0}}, dup_count_r} + {{CNT_WIDTH{1'b0}}, popcount(dup_vec_s)};
        if (dup_sum_s > SAT_V) begin
            dup_next_s = {CNT_WIDTH{1'b1}};
        end else begin
            dup_next_s = dup_sum_s[CNT_WIDTH-1:0];
        end
    end

    // State register: reset beats flush; flush keeps the duplicate statistic.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_r   <= ZERO_V;
            out_valid_r <= 1'b0;
            out_index_r <= {IDX_W{1'b0}};
            dup_count_r <= {CNT_WIDTH{1'b0}};
        end else if (flush) begin
            pending_r   <= ZERO_V;
            out_valid_r <= 1'b0;
            out_index_r <= {IDX_W{1'b0}};
        end else begin
            pending_r   <= (pending_r & ~issue_mask_s) | req_in;
            dup_count_r <= dup_next_s;
            if (load_slot_s) begin
                out_valid_r <= issue_s;
                if (issue_s) begin
                    out_index_r <= sel_s;
                end else begin
                    out_index_r <= out_index_r;
                end
            end else begin
                out_valid_r <= out_valid_r;
            end
        end
    end

    assign out_valid     = out_valid_r;
    assign out_index     = out_index_r;
    assign pending       = pending_r;
    assign pending_count = popcount(pending_r);
    assign dup_count     = dup_count_r;
    assign idle          = (pending_r == ZERO_V) && !out_valid_r;

endmodule

// File: tb/tb_pending_request_scheduler.sv
// Scoreboard bench for pending_request_scheduler: directed scenarios followed by
// random traffic, checked against a set/queue-level reference model.
module tb_pending_request_scheduler;

    localparam int W  = 8;
    localparam int CW = 3;
    localparam int IW = 3;
    localparam int PW = 4;
    localparam int DUP_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          out_ready = 1'b1;
    logic [W-1:0]  req_in = '0;
    logic          out_valid;
    logic [IW-1:0] out_index;
    logic [W-1:0]  pending;
    logic [PW-1:0] pending_count;
    logic [CW-1:0] dup_count;
    logic          idle;

    int checks = 0;
    int passes = 0;

    // reference model state (meaning: after the most recent rising edge)
    bit m_pend[W];
    int m_inflight[$];
    int sb_q[$];
    int m_dup = 0;
    bit started = 0;

    always #5 clk = ~clk;

    pending_request_scheduler #(.INPUT_WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .req_in(req_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
        .pending(pending), .pending_count(pending_count), .dup_count(dup_count),
        .idle(idle)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    endtask

    task automatic cyc(input logic r, input logic f, input logic [W-1:0] rq, input logic rdy);
        @(negedge clk);
        #1;
        rst_n = r; flush = f; req_in = rq; out_ready = rdy;
    endtask

    // Reference model: pending is a set of indices, the output slot a one-entry queue.
    always @(posedge clk) begin
        int sel;
        int n;
        started = 1;
        if (!rst_n) begin
            foreach (m_pend[i]) m_pend[i] = 0;
            m_inflight.delete();
            sb_q.delete();
            m_dup = 0;
        end else if (flush) begin
            foreach (m_pend[i]) m_pend[i] = 0;
            m_inflight.delete();
            sb_q.delete();
        end else begin
            sel = -1;
            n = 0;
            if (m_inflight.size() == 0 || out_ready) begin
                if (m_inflight.size() != 0) void'(m_inflight.pop_front());
                for (int i = W - 1; i >= 0; i--) if (m_pend[i]) sel = i;
                if (sel >= 0) begin
                    m_pend[sel] = 0;
                    m_inflight.push_back(sel);
                    sb_q.push_back(sel);
                end
            end
            for (int i = 0; i < W; i++) if (req_in[i] && m_pend[i]) n++;
            for (int i = 0; i < W; i++) if (req_in[i]) m_pend[i] = 1;
            m_dup = (m_dup + n > DUP_MAX) ? DUP_MAX : m_dup + n;
        end
    end

    // Monitor: just before each rising edge, compare state and consume accepted issues.
    always @(negedge clk) begin
        logic [W-1:0] mp;
        int exp_idx;
        #4;
        if (started) begin
            mp = '0;
            for (int i = 0; i < W; i++) mp[i] = m_pend[i];
            check("out_valid", out_valid, m_inflight.size() != 0);
            if (m_inflight.size() != 0) check("out_index", out_index, m_inflight[0]);
            check("pending", pending, mp);
            check("pending_count", pending_count, $countones(mp));
            check("dup_count", dup_count, m_dup);
            check("idle", idle, (mp == '0) && (m_inflight.size() == 0));
            if (out_valid && out_ready) begin
                check("sb_has_entry", sb_q.size() > 0, 1);
                if (sb_q.size() > 0) begin
                    exp_idx = sb_q.pop_front();
                    check("accepted_index", out_index, exp_idx);
                end
            end
        end
    end

    initial begin
        // reset
        cyc(0, 0, 8'h00, 1'b1);
        cyc(1, 0, 8'h00, 1'b1);
        // two requests, issued in index order with 2-cycle latency
        cyc(1, 0, 8'b0010_0100, 1'b1);
        repeat (5) cyc(1, 0, 8'h00, 1'b1);
        // all bits, stalled consumer, then release
        cyc(1, 0, 8'hFF, 1'b0);
        repeat (3) cyc(1, 0, 8'h00, 1'b0);
        // duplicate on a pending bit while stalled on another index
        cyc(1, 0, 8'h08, 1'b0);
        repeat (10) cyc(1, 0, 8'h00, 1'b1);
        // bit 3 in flight and stalled, then re-requested: not a duplicate, issues twice
        cyc(1, 0, 8'h08, 1'b0);
        repeat (2) cyc(1, 0, 8'h00, 1'b0);
        cyc(1, 0, 8'h08, 1'b0);
        repeat (4) cyc(1, 0, 8'h00, 1'b1);
        // drive duplicate counter into saturation, then flush with requests present
        cyc(1, 0, 8'hF0, 1'b0);
        repeat (5) cyc(1, 0, 8'hF0, 1'b0);
        cyc(1, 1, 8'h81, 1'b1);
        repeat (2) cyc(1, 0, 8'h00, 1'b1);
        // reset while valid; request during reset must never issue
        cyc(1, 0, 8'h03, 1'b1);
        cyc(1, 0, 8'h00, 1'b1);
        cyc(0, 0, 8'h01, 1'b1);
        repeat (4) cyc(1, 0, 8'h00, 1'b1);
        // random traffic
        for (int k = 0; k < 3000; k++) begin
            cyc($urandom_range(0, 199) != 0,
                $urandom_range(0, 79) == 0,
                ($urandom_range(0, 3) == 0) ? 8'h00 : W'($urandom & $urandom & $urandom),
                $urandom_range(0, 3) != 0);
        end
        repeat (12) cyc(1, 0, 8'h00, 1'b1);
        @(negedge clk);
        #6;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/pending_request_scheduler.md
Name: pending_request_scheduler

Overview:
- Sequential stage directly upstream of the priority encoder's consumers. It collects request pulses into a pending-bit register and issues them one at a time, lowest index first.
- Issued indices go out through a registered valid/ready port.
- Provides occupancy and duplicate-request statistics for the surrounding selection datapath.

Parameters:
- INPUT_WIDTH, 8, number of request lines; legal range 2..64.
- CNT_WIDTH, 8, width of the saturating duplicate-request counter.
- Derived (localparam, not overridable): IDX_W = $clog2(INPUT_WIDTH); PC_W = $clog2(INPUT_WIDTH+1).

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- flush  input  1  synchronous clear of all pending and in-flight work.
- req_in  input  INPUT_WIDTH  request pulses, one bit per source, sampled every cycle.
- out_valid  output  1  out_index holds an issued request.
- out_ready  input  1  consumer accepts out_index when out_valid && out_ready.
- out_index  output  IDX_W  index of the issued request.
- pending  output  INPUT_WIDTH  current pending-bit register (excludes the in-flight index).
- pending_count  output  PC_W  popcount of pending.
- dup_count  output  CNT_WIDTH  saturating count of requests that hit an already-pending bit.
- idle  output  1  high when pending == 0 and out_valid == 0.

Behaviour:
- Reset (rst_n low at clock edge):
  - pending = 0, out_valid = 0, out_index = 0, dup_count = 0.
  - req_in is ignored in that cycle.
  - Reset has priority over flush.
- Flush (rst_n high, flush high):
  - pending = 0, out_valid = 0, out_index = 0.
  - dup_count is retained.
  - req_in is ignored in that cycle.
- Output register can load ("load slot") when !out_valid || out_ready.
- Issue, on a load slot with pending != 0:
  - sel = lowest set index of the current pending register.
  - out_index <= sel; out_valid <= 1; bit sel is removed from pending.
- On a load slot with pending == 0: out_valid <= 0; out_index holds its last value.
- While out_valid && !out_ready: out_index and out_valid stay stable. No bit is removed from pending.
- Pending update every non-reset, non-flush cycle:
  - pending_next = (pending & ~issue_mask) | req_in.
  - issue_mask is the one-hot of sel when an issue occurs, else 0.
- No bypass: a request sampled in cycle N enters pending at edge N+1. It can appear on out_index at edge N+2 at the earliest.
  - Minimum latency from req_in to out_valid is 2 cycles.
- Duplicates:
  - For each bit i with req_in[i] && pending[i] && !issue_mask[i], that request merges (no second issue).
  - dup_count increments by the number of such bits that cycle, saturating at 2^CNT_WIDTH-1.
  - A request on the bit being issued in the same cycle is not a duplicate. It re-sets pending[i], so index i will issue again.
  - A request equal to the in-flight out_index is not a duplicate. It sets pending and issues again later.
- Combinational outputs: pending_count and idle are computed from registered state only. pending mirrors the register.
- Throughput: with out_ready held high, one issue per cycle while pending != 0.
- No starvation guarantee beyond fixed priority; a continuously re-requesting low index can starve higher ones (documented, intended).

Test Plan:
- Reset, then req_in=8'b0010_0100 for 1 cycle, out_ready=1 -> out_valid rises at cycle +2 with out_index=2, then out_index=5 next cycle, then out_valid=0. pending_count goes 2,1,0. idle=1 after.
- req_in=8'hFF for 1 cycle, out_ready=0 for 3 cycles, then 1 -> out_index=0 held stable while stalled, pending=8'hFE. After release, indices 1..7 issue on consecutive cycles.
- Pending=8'b0000_1000 (bit 3, not yet issued), req_in=8'b0000_1000 while out_ready=0 and out_valid=1 for another index -> dup_count +1, pending unchanged; bit 3 issues only once.
- Bit 3 in flight (out_valid=1, out_index=3, stalled), req_in bit 3 asserted -> dup_count unchanged, pending[3]=1; after acceptance, index 3 issues a second time.
- CNT_WIDTH=2, 5 duplicate hits -> dup_count saturates at 3. Then flush with req_in=8'h81 the same cycle -> pending=0, out_valid=0, dup_count stays 3, idle=1 next cycle.
- INPUT_WIDTH=2, req_in=2'b11 then rst_n=0 while out_valid=1 -> all outputs return to reset values at that edge. A req_in asserted during reset is never issued.
